// File: rtl/edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// edge_detect_pkg
// Shared types and constants for the cartoonifier edge pass.
//   pixel_t     : 24bpp RGB pixel, R[23:16] G[15:8] B[7:0]
//   intensity_t : 8-bit intensity / threshold sample
//   frame_t     : 3x3 pixels, element 8 = p00 (MSBs) ... element 0 = p22
//   grid_t      : 3x3 intensities, same ordering as frame_t
// -----------------------------------------------------------------------------
package edge_detect_pkg;

    localparam int PIX_W = 24;
    localparam int INT_W = 8;
    localparam int MAG_W = 11;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [INT_W-1:0] intensity_t;
    typedef pixel_t     [8:0] frame_t;
    typedef intensity_t [8:0] grid_t;

    // Sobel kernel weights: outer taps weigh 1, the tap in line with the centre weighs 2.
    localparam logic [9:0] SOBEL_K_OUTER = 10'd1;
    localparam logic [9:0] SOBEL_K_MID   = 10'd2;

    // Packed-array element holding row r, column c (row-major, p00 in the MSBs).
    function automatic int grid_idx(input int r, input int c);
        return 8 - (3 * r + c);
    endfunction

    // One Sobel column/row sum: outer + 2*mid + outer, max 1020, fits 10 bits.
    function automatic logic [9:0] sobel_sum3(input intensity_t a,
                                              input intensity_t b,
                                              input intensity_t c);
        return (SOBEL_K_OUTER * {2'b00, a}) + (SOBEL_K_MID * {2'b00, b}) +
               (SOBEL_K_OUTER * {2'b00, c});
    endfunction

    // Magnitude of a signed gradient; |-1020..1020| always fits.
    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [MAG_W-1:0] g);
        logic [MAG_W-1:0] res;
        if (g[MAG_W-1] == 1'b1) begin
            res = MAG_W'(-g);
        end else begin
            res = MAG_W'(g);
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_detect_pixel_intensity.sv
// -----------------------------------------------------------------------------
// pixel_intensity
// Combinational RGB -> 8-bit intensity converter.
//   pix_i : RGB pixel
//   int_o : intensity
// Build option EDGE_DETECT_LUMA_EN selects the luma weighting
// (77R + 150G + 29B) >> 8; otherwise (R + 2G + B) >> 2 is used.
// -----------------------------------------------------------------------------
module pixel_intensity
    import edge_detect_pkg::*;
(
    input  pixel_t     pix_i,
    output intensity_t int_o
);

    logic [7:0] r_s;
    logic [7:0] g_s;
    logic [7:0] b_s;

    assign r_s = pix_i[23:16];
    assign g_s = pix_i[15:8];
    assign b_s = pix_i[7:0];

`ifdef EDGE_DETECT_LUMA_EN
    // Weights sum to 256, so the 16-bit sum tops out at 65280 and never wraps.
    logic [15:0] luma_s;
    assign luma_s = (16'd77  * {8'd0, r_s}) +
                    (16'd150 * {8'd0, g_s}) +
                    (16'd29  * {8'd0, b_s});
    assign int_o  = intensity_t'(luma_s >> 8);
`else
    // Max 1020 fits 10 bits; the shift brings it back to 0..255.
    logic [9:0] sum_s;
    assign sum_s = {2'b00, r_s} + {1'b0, g_s, 1'b0} + {2'b00, b_s};
    assign int_o = intensity_t'(sum_s >> 2);
`endif

endmodule

// File: rtl/edge_detect.sv
// -----------------------------------------------------------------------------
// edge_detect
// Two-stage pixel pipeline: stage 1 registers the 3x3 intensity grid, stage 2
// applies Sobel and flags the centre pixel when |Gx|+|Gy| > threshold.
//   clk, rst          : clock, asynchronous active-high reset
//   intensity_enable  : pixel_data valid this cycle
//   pixel_data        : 3x3 RGB frame, p00 in [215:192]
//   threshold         : edge threshold (used in stage 2)
//   i_grid            : registered intensities, i00 in [71:64]
//   edgedetect_enable : i_grid valid
//   is_edge           : centre pixel is an edge
//   edge_valid        : is_edge valid
// Build option EDGE_DETECT_LUMA_EN (inside pixel_intensity) selects luma weighting.
// -----------------------------------------------------------------------------
module edge_detect
    import edge_detect_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       intensity_enable,
    input  frame_t     pixel_data,
    input  intensity_t threshold,
    output grid_t      i_grid,
    output logic       edgedetect_enable,
    output logic       is_edge,
    output logic       edge_valid
);

    grid_t      int_s;
    grid_t      i_grid_d;
    grid_t      i_grid_q;
    logic       ed_en_q;
    logic       is_edge_d;
    logic       is_edge_q;
    logic       edge_valid_q;

    logic signed [MAG_W-1:0] gx_s;
    logic signed [MAG_W-1:0] gy_s;
    logic        [MAG_W-1:0] mag_s;

    genvar k;
    generate
        for (k = 0; k < 9; k++) begin : g_conv
            pixel_intensity u_conv (
                .pix_i (pixel_data[k]),
                .int_o (int_s[k])
            );
        end
    endgenerate

    // Stage-1 next state: capture a new grid only on enabled cycles.
    always_comb begin
        i_grid_d = i_grid_q;
        if (intensity_enable == 1'b1) begin
            i_grid_d = int_s;
        end else begin
            i_grid_d = i_grid_q;
        end
    end

    // Sobel gradients over the registered grid (sums are non-negative, difference is signed).
    always_comb begin
        gx_s = $signed({1'b0, sobel_sum3(i_grid_q[grid_idx(0, 2)], i_grid_q[grid_idx(1, 2)],
                                         i_grid_q[grid_idx(2, 2)])}) -
               $signed({1'b0, sobel_sum3(i_grid_q[grid_idx(0, 0)], i_grid_q[grid_idx(1, 0)],
                                         i_grid_q[grid_idx(2, 0)])});
        gy_s = $signed({1'b0, sobel_sum3(i_grid_q[grid_idx(2, 0)], i_grid_q[grid_idx(2, 1)],
                                         i_grid_q[grid_idx(2, 2)])}) -
               $signed({1'b0, sobel_sum3(i_grid_q[grid_idx(0, 0)], i_grid_q[grid_idx(0, 1)],
                                         i_grid_q[grid_idx(0, 2)])});
        mag_s = abs_grad(gx_s) + abs_grad(gy_s);
    end

    // Stage-2 next state: strictly-greater compare, hold while the grid is not valid.
    always_comb begin
        is_edge_d = is_edge_q;
        if (ed_en_q == 1'b1) begin
            is_edge_d = (mag_s > {3'b000, threshold});
        end else begin
            is_edge_d = is_edge_q;
        end
    end

    // Pipeline registers for both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grid_q     <= '0;
            ed_en_q      <= 1'b0;
            is_edge_q    <= 1'b0;
            edge_valid_q <= 1'b0;
        end else begin
            i_grid_q     <= i_grid_d;
            ed_en_q      <= intensity_enable;
            is_edge_q    <= is_edge_d;
            edge_valid_q <= ed_en_q;
        end
    end

    assign i_grid            = i_grid_q;
    assign edgedetect_enable = ed_en_q;
    assign is_edge           = is_edge_q;
    assign edge_valid        = edge_valid_q;

endmodule

// File: tb/tb_edge_detect.sv
module tb_edge_detect;

    logic         clk;
    logic         rst;
    logic         intensity_enable;
    logic [215:0] pixel_data;
    logic [7:0]   threshold;
    logic [71:0]  i_grid;
    logic         edgedetect_enable;
    logic         is_edge;
    logic         edge_valid;

    int checks;
    int failures;

    edge_detect dut (
        .clk               (clk),
        .rst               (rst),
        .intensity_enable  (intensity_enable),
        .pixel_data        (pixel_data),
        .threshold         (threshold),
        .i_grid            (i_grid),
        .edgedetect_enable (edgedetect_enable),
        .is_edge           (is_edge),
        .edge_valid        (edge_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] left_px;
        logic [23:0] rest_px;
        logic [7:0]  thr;
        logic [7:0]  exp_left;
        logic [7:0]  exp_rest;
        logic        exp_edge;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [215:0] make_frame(input logic [23:0] left, input logic [23:0] rest);
        logic [215:0] f;
        f = '0;
        for (int k = 0; k < 9; k++) begin
            f[215 - 24 * k -: 24] = ((k % 3) == 0) ? left : rest;
        end
        return f;
    endfunction

    function automatic logic [71:0] make_grid(input logic [7:0] left, input logic [7:0] rest);
        logic [71:0] g;
        g = '0;
        for (int k = 0; k < 9; k++) begin
            g[71 - 8 * k -: 8] = ((k % 3) == 0) ? left : rest;
        end
        return g;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [215:0] frame, input logic [7:0] thr);
        @(negedge clk);
        intensity_enable = en;
        pixel_data       = frame;
        threshold        = thr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;

        //            left         rest         thr     expL   expR   edge
        vecs[0] = '{24'h808080, 24'h808080, 8'd50,  8'h80, 8'h80, 1'b0};
        vecs[1] = '{24'h000000, 24'hFFFFFF, 8'd50,  8'h00, 8'hFF, 1'b1};
        vecs[2] = '{24'h000000, 24'hFFFFFF, 8'd255, 8'h00, 8'hFF, 1'b1};
        vecs[3] = '{24'h000000, 24'h0C0C0C, 8'd48,  8'h00, 8'h0C, 1'b0};
        vecs[4] = '{24'h000000, 24'h0C0C0C, 8'd47,  8'h00, 8'h0C, 1'b1};
`ifdef EDGE_DETECT_LUMA_EN
        // luma(0x102030) = 7424 >> 8 = 29, mag = 4*29 = 116
        vecs[5] = '{24'h102030, 24'h000000, 8'd10,  8'd29,  8'h00, 1'b1};
        vecs[6] = '{24'h102030, 24'h000000, 8'd200, 8'd29,  8'h00, 1'b0};
`else
        // (16 + 64 + 48) >> 2 = 32, mag = 4*32 = 128
        vecs[5] = '{24'h102030, 24'h000000, 8'd10,  8'd32,  8'h00, 1'b1};
        vecs[6] = '{24'h102030, 24'h000000, 8'd200, 8'd32,  8'h00, 1'b0};
`endif

        rst              = 1'b1;
        intensity_enable = 1'b0;
        pixel_data       = '0;
        threshold        = 8'd0;
        #3;
        check("reset_grid", i_grid, 72'd0);
        check("reset_flags", {68'd0, edgedetect_enable, is_edge, edge_valid, 1'b0}, 72'd0);

        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("idle_after_release", {69'd0, edgedetect_enable, is_edge, edge_valid}, 72'd0);

        // Table-driven: one enabled frame, then a disabled cycle with garbage data.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, make_frame(vecs[i].left_px, vecs[i].rest_px), vecs[i].thr);
            tick();
            check($sformatf("v%0d_s1_valid", i), {71'd0, edgedetect_enable}, 72'd1);
            check($sformatf("v%0d_grid", i), i_grid, make_grid(vecs[i].exp_left, vecs[i].exp_rest));
            drive(1'b0, ~make_frame(vecs[i].left_px, vecs[i].rest_px), vecs[i].thr);
            tick();
            check($sformatf("v%0d_edge_valid", i), {71'd0, edge_valid}, 72'd1);
            check($sformatf("v%0d_is_edge", i), {71'd0, is_edge}, {71'd0, vecs[i].exp_edge});
            check($sformatf("v%0d_grid_hold", i), i_grid, make_grid(vecs[i].exp_left, vecs[i].exp_rest));
            check($sformatf("v%0d_s1_drop", i), {71'd0, edgedetect_enable}, 72'd0);
        end

        // Back-to-back: step frame then uniform frame, then drop enable.
        drive(1'b1, make_frame(24'h000000, 24'hFFFFFF), 8'd50);
        tick();
        drive(1'b1, make_frame(24'h808080, 24'h808080), 8'd50);
        tick();
        check("b2b_first_valid", {71'd0, edge_valid}, 72'd1);
        check("b2b_first_edge", {71'd0, is_edge}, 72'd1);
        drive(1'b0, make_frame(24'h000000, 24'hFFFFFF), 8'd50);
        tick();
        check("b2b_second_valid", {71'd0, edge_valid}, 72'd1);
        check("b2b_second_edge", {71'd0, is_edge}, 72'd0);
        check("b2b_s1_drop", {71'd0, edgedetect_enable}, 72'd0);
        tick();
        check("b2b_valid_falls", {71'd0, edge_valid}, 72'd0);
        check("b2b_edge_holds", {71'd0, is_edge}, 72'd0);

        // Asynchronous reset mid-stream, away from any clock edge.
        drive(1'b1, make_frame(24'h000000, 24'hFFFFFF), 8'd50);
        tick();
        check("pre_reset_s1", {71'd0, edgedetect_enable}, 72'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_grid", i_grid, 72'd0);
        check("async_reset_flags", {69'd0, edgedetect_enable, is_edge, edge_valid}, 72'd0);
        @(negedge clk);
        rst = 1'b0;
        intensity_enable = 1'b0;
        tick();
        tick();
        check("post_reset_idle", {69'd0, edgedetect_enable, is_edge, edge_valid}, 72'd0);
        drive(1'b1, make_frame(24'h000000, 24'hFFFFFF), 8'd50);
        tick();
        check("post_reset_one_clk", {70'd0, is_edge, edge_valid}, 72'd0);
        drive(1'b0, make_frame(24'h000000, 24'hFFFFFF), 8'd50);
        tick();
        check("post_reset_two_clk", {70'd0, is_edge, edge_valid}, 72'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
